// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
//   rx_state_t : receiver FSM states
//   OVERSAMPLE : oversample ticks per bit
//   SAMPLE_LO/MID/HI : sample points used for the majority-vote bit decision
//   majority3  : 2-of-3 vote helper
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_LO  = 7;
    localparam int SAMPLE_MID = 8;
    localparam int SAMPLE_HI  = 9;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: serial input, run-time configuration and received-data outputs of
// the UART receiver.
//   divisor       : sys_clk cycles per oversample tick (0 behaves as 1)
//   uart_rx       : serial line, idle high
//   rx_data       : last received payload
//   rx_done       : one-cycle pulse, rx_data and error flags valid
//   rx_frame_err  : stop bit was sampled 0
//   rx_busy       : frame reception in progress
//   parity_odd    : (UART_RX_PARITY_EN) 1 = odd parity, 0 = even
//   rx_parity_err : (UART_RX_PARITY_EN) received parity bit mismatch
// master = receiver side, slave = the block feeding/consuming it.
interface uart_receiver_if #(
    parameter int DATA_BITS = 8,
    parameter int DIV_W     = 16
);
    logic [DIV_W-1:0]     divisor;
    logic                 uart_rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_done;
    logic                 rx_frame_err;
    logic                 rx_busy;
`ifdef UART_RX_PARITY_EN
    logic                 parity_odd;
    logic                 rx_parity_err;
`endif

    modport master (
        input  divisor, uart_rx,
`ifdef UART_RX_PARITY_EN
        input  parity_odd,
        output rx_parity_err,
`endif
        output rx_data, rx_done, rx_frame_err, rx_busy
    );

    modport slave (
        output divisor, uart_rx,
`ifdef UART_RX_PARITY_EN
        output parity_odd,
        input  rx_parity_err,
`endif
        input  rx_data, rx_done, rx_frame_err, rx_busy
    );

endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator shared by the UART transmit and receive paths.
//   clk, rst_n : clock, synchronous active-low reset
//   restart    : reload from divisor now (latches divisor for the coming frame)
//   divisor    : clk cycles per tick, 0 treated as 1
//   tick       : one-cycle pulse every divisor cycles after restart
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    input  logic [DIV_W-1:0] divisor,
    output logic             tick
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_eff;

    assign div_eff = (divisor == '0) ? DIV_W'(1) : divisor;

    // div_q holds the divisor captured at restart so mid-frame changes are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= DIV_W'(1);
            cnt   <= '0;
        end else if (restart) begin
            div_q <= div_eff;
            cnt   <= div_eff - DIV_W'(1);
        end else if (cnt == '0) begin
            cnt   <= div_q - DIV_W'(1);
        end else begin
            cnt   <= cnt - DIV_W'(1);
        end
    end

    assign tick = (cnt == '0) && !restart;

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampling UART receiver for start + DATA_BITS (+ parity) + stop
// frames, LSB first.
//   sys_clk   : system clock, rising edge
//   sys_rst_n : synchronous active-low reset
//   bus       : uart_receiver_if.master (divisor, uart_rx in; rx_data, rx_done,
//               rx_frame_err, rx_busy out; parity_odd / rx_parity_err with parity)
// Build option: define UART_RX_PARITY_EN to add a parity bit between data and stop.
module uart_receiver #(
    parameter int DATA_BITS = 8,
    parameter int DIV_W     = 16
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    uart_receiver_if.master bus
);
    import uart_pkg::*;

    localparam int IDX_W  = $clog2(DATA_BITS);
    localparam int SCNT_W = $clog2(OVERSAMPLE);

    rx_state_t            state;
    logic                 rx_meta, rxs;
    logic [SCNT_W-1:0]    scnt;
    logic [IDX_W-1:0]     bidx;
    logic [DATA_BITS-1:0] shreg;
    logic                 s_lo, s_mid;
    logic                 tick, start_det, decision;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_done_q, rx_frame_err_q, rx_busy_q;
`ifdef UART_RX_PARITY_EN
    logic                 par_err_pend, rx_parity_err_q;
`endif

    // Two-flop synchroniser, resets to the idle (high) line level.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= bus.uart_rx;
            rxs     <= rx_meta;
        end
    end

    assign start_det = (state == IDLE) && !rxs;

    uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .restart (start_det),
        .divisor (bus.divisor),
        .tick    (tick)
    );

    // Third vote is the live level at the SAMPLE_HI tick.
    assign decision = majority3(s_lo, s_mid, rxs);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state          <= IDLE;
            scnt           <= '0;
            bidx           <= '0;
            shreg          <= '0;
            s_lo           <= 1'b1;
            s_mid          <= 1'b1;
            rx_data_q      <= '0;
            rx_done_q      <= 1'b0;
            rx_frame_err_q <= 1'b0;
            rx_busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_pend    <= 1'b0;
            rx_parity_err_q <= 1'b0;
`endif
        end else begin
            rx_done_q <= 1'b0;
            if (state == IDLE) begin
                if (!rxs) begin
                    state     <= START;
                    rx_busy_q <= 1'b1;
                    scnt      <= '0;
                    bidx      <= '0;
                end
            end else if (tick) begin
                scnt <= scnt + SCNT_W'(1);   // wraps every bit
                if (scnt == SCNT_W'(SAMPLE_LO))  s_lo  <= rxs;
                if (scnt == SCNT_W'(SAMPLE_MID)) s_mid <= rxs;
                if (scnt == SCNT_W'(SAMPLE_HI)) begin
                    case (state)
                        START: begin
                            if (decision) begin
                                state     <= IDLE;   // false start
                                rx_busy_q <= 1'b0;
                            end else begin
                                state <= DATA;
                            end
                        end
                        DATA: begin
                            shreg <= {decision, shreg[DATA_BITS-1:1]};
                            if (bidx == IDX_W'(DATA_BITS-1)) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                bidx <= bidx + IDX_W'(1);
                            end
                        end
`ifdef UART_RX_PARITY_EN
                        PARITY: begin
                            // expected bit = ^data for even, ~^data for odd
                            par_err_pend <= decision ^ (^shreg) ^ bus.parity_odd;
                            state        <= STOP;
                        end
`endif
                        STOP: begin
                            // Leave at mid-stop so a following start edge is seen at once.
                            rx_data_q      <= shreg;
                            rx_frame_err_q <= ~decision;
                            rx_done_q      <= 1'b1;
                            rx_busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            rx_parity_err_q <= par_err_pend;
`endif
                            state          <= IDLE;
                        end
                        default: begin
                            state     <= IDLE;
                            rx_busy_q <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.rx_data      = rx_data_q;
    assign bus.rx_done      = rx_done_q;
    assign bus.rx_frame_err = rx_frame_err_q;
    assign bus.rx_busy      = rx_busy_q;
`ifdef UART_RX_PARITY_EN
    assign bus.rx_parity_err = rx_parity_err_q;
`endif

endmodule
